// File: rtl/pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_seq
// Description : Pass sequencer for the PE array. Each accepted start runs one
//               neuron-layer pass: clear, bias load, element streaming with a
//               2-stage weight-capture/accumulate enable pipe, then psum latch
//               and a backpressured drain of N_PEs results.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32,
    parameter int N_PEs      = 16,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      vec_len,
    input  logic [N_PEs-1:0]      pe_mask,
    output logic                  busy,
    output logic                  done,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_ia,
    input  logic                  src_sign,
    output logic                  rst_pe_relu_reg,
    output logic [N_PEs-1:0]      wea_reg1,
    output logic [N_PEs-1:0]      wea_reg2,
    output logic                  shift,
    output logic                  load_bias,
    output logic                  load_psum,
    output logic                  sel_pe_reg,
    output logic [DATA_WIDTH-1:0] ia,
    output logic                  ia_sign,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_data
);

    localparam int DCNT_W = (N_PEs > 1) ? $clog2(N_PEs) : 1;
    localparam logic [DCNT_W-1:0] C_LAST_WORD = DCNT_W'(N_PEs - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_BIAS  = 3'd2,
        S_ACC   = 3'd3,
        S_FLUSH = 3'd4,
        S_LOAD  = 3'd5,
        S_DRAIN = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Reset synchronizer
    logic rst_meta_q, rst_meta_d;
    logic rst_sync_q, rst_sync_d;
    logic rst_n;

    // Sequencer state and pass context
    state_t              state_q, state_d;
    logic [LEN_W-1:0]    vec_len_q, vec_len_d;
    logic [N_PEs-1:0]    pe_mask_q, pe_mask_d;
    logic [LEN_W-1:0]    elem_cnt_q, elem_cnt_d;
    logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;

    // Registered outputs
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  src_ready_q, src_ready_d;
    logic                  relu_q, relu_d;
    logic [N_PEs-1:0]      wea1_q, wea1_d;
    logic [N_PEs-1:0]      wea2_q, wea2_d;
    logic                  load_bias_q, load_bias_d;
    logic                  load_psum_q, load_psum_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] ia_q, ia_d;
    logic                  ia_sign_q, ia_sign_d;
    logic                  out_valid_q, out_valid_d;

    logic w_accept;
    logic w_handshake;

    assign w_accept    = src_valid & src_ready_q;
    assign w_handshake = out_valid_q & out_ready;
    assign rst_n       = rst_sync_q;

    // Synchronizer next values: shift a one through two stages after release
    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    // Reset assertion is immediate; release reaches the core two edges later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    // Next-state logic, pass context capture and element/drain counting
    always_comb begin
        state_d     = state_q;
        vec_len_d   = vec_len_q;
        pe_mask_d   = pe_mask_q;
        elem_cnt_d  = elem_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_len_d  = vec_len;
                    pe_mask_d  = pe_mask;
                    elem_cnt_d = '0;
                    state_d    = S_CLR;
                end
            end
            S_CLR:   state_d = S_BIAS;
            S_BIAS:  state_d = (vec_len_q != '0) ? S_ACC : S_LOAD;
            S_ACC: begin
                if (w_accept) begin
                    elem_cnt_d = elem_cnt_q + LEN_W'(1);
                    if ((elem_cnt_q + LEN_W'(1)) == vec_len_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_LOAD;
            S_LOAD: begin
                drain_cnt_d = '0;
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_handshake) begin
                    drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                    if (drain_cnt_q == C_LAST_WORD) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values decoded from the upcoming state so every control is a flop
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        src_ready_d = (state_d == S_ACC);
        relu_d      = (state_d == S_CLR);
        load_bias_d = (state_d == S_BIAS);
        load_psum_d = (state_d == S_LOAD);
        sel_d       = (state_d == S_LOAD) || (state_d == S_DRAIN);
        out_valid_d = (state_d == S_DRAIN);
        // Weight capture follows the accept by one cycle, accumulate by two
        wea1_d      = w_accept ? pe_mask_q : '0;
        wea2_d      = wea1_q;
        ia_d        = w_accept ? src_ia : ia_q;
        ia_sign_d   = w_accept ? src_sign : ia_sign_q;
    end

    // State, context and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_len_q   <= '0;
            pe_mask_q   <= '0;
            elem_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            src_ready_q <= 1'b0;
            relu_q      <= 1'b0;
            wea1_q      <= '0;
            wea2_q      <= '0;
            load_bias_q <= 1'b0;
            load_psum_q <= 1'b0;
            sel_q       <= 1'b0;
            ia_q        <= '0;
            ia_sign_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_len_q   <= vec_len_d;
            pe_mask_q   <= pe_mask_d;
            elem_cnt_q  <= elem_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            src_ready_q <= src_ready_d;
            relu_q      <= relu_d;
            wea1_q      <= wea1_d;
            wea2_q      <= wea2_d;
            load_bias_q <= load_bias_d;
            load_psum_q <= load_psum_d;
            sel_q       <= sel_d;
            ia_q        <= ia_d;
            ia_sign_q   <= ia_sign_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign src_ready       = src_ready_q;
    assign rst_pe_relu_reg = relu_q;
    assign wea_reg1        = wea1_q;
    assign wea_reg2        = wea2_q;
    assign load_bias       = load_bias_q;
    assign load_psum       = load_psum_q;
    assign sel_pe_reg      = sel_q;
    assign ia              = ia_q;
    assign ia_sign         = ia_sign_q;
    assign out_valid       = out_valid_q;
    // Shift only on a completed handshake so a stalled consumer holds the chain
    assign shift           = out_valid_q & out_ready;
    assign out_data        = psum_in;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_seq
// Description : Directed and randomized passes through pe_array_seq against a
//               cycle-level expected schedule and a behavioural PE array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_seq;

    localparam int DW = 8;
    localparam int PW = 32;
    localparam int N  = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] vec_len;
    logic [N-1:0]  pe_mask;
    logic          busy, done;
    logic          src_valid, src_ready;
    logic [DW-1:0] src_ia;
    logic          src_sign;
    logic          rst_pe_relu_reg;
    logic [N-1:0]  wea_reg1, wea_reg2;
    logic          shift, load_bias, load_psum, sel_pe_reg;
    logic [DW-1:0] ia;
    logic          ia_sign;
    logic [PW-1:0] psum_in;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_array_seq #(
        .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .N_PEs(N), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len), .pe_mask(pe_mask),
        .busy(busy), .done(done), .src_valid(src_valid), .src_ready(src_ready),
        .src_ia(src_ia), .src_sign(src_sign), .rst_pe_relu_reg(rst_pe_relu_reg),
        .wea_reg1(wea_reg1), .wea_reg2(wea_reg2), .shift(shift), .load_bias(load_bias),
        .load_psum(load_psum), .sel_pe_reg(sel_pe_reg), .ia(ia), .ia_sign(ia_sign),
        .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Contribution of one activation: signed or unsigned extension
    function automatic logic [PW-1:0] elem_val(input logic [DW-1:0] d, input logic s);
        return s ? PW'($signed(d)) : PW'(d);
    endfunction

    // Behavioural PE array: PE i multiplies the activation by (i+1)
    logic [PW-1:0] bias_arr  [N];
    logic [PW-1:0] acc_arr   [N];
    logic [PW-1:0] wreg_arr  [N];
    logic [PW-1:0] chain_arr [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst_pe_relu_reg)  acc_arr[i] <= '0;
            else if (load_bias)   acc_arr[i] <= bias_arr[i];
            else if (wea_reg2[i]) acc_arr[i] <= acc_arr[i] + wreg_arr[i];
            if (wea_reg1[i]) wreg_arr[i] <= elem_val(ia, ia_sign) * PW'(i + 1);
            if (load_psum)   chain_arr[i] <= acc_arr[i] + (wea_reg2[i] ? wreg_arr[i] : '0);
            else if (shift)  chain_arr[i] <= (i == 0) ? '0 : chain_arr[(i + N - 1) % N];
        end
    end
    assign psum_in = chain_arr[N-1];

    task automatic chk(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag, input int t);
        chk({tag, "_busy"},      t, 64'(busy),            64'(0));
        chk({tag, "_done"},      t, 64'(done),            64'(0));
        chk({tag, "_src_ready"}, t, 64'(src_ready),       64'(0));
        chk({tag, "_relu"},      t, 64'(rst_pe_relu_reg), 64'(0));
        chk({tag, "_wea1"},      t, 64'(wea_reg1),        64'(0));
        chk({tag, "_wea2"},      t, 64'(wea_reg2),        64'(0));
        chk({tag, "_shift"},     t, 64'(shift),           64'(0));
        chk({tag, "_load_bias"}, t, 64'(load_bias),       64'(0));
        chk({tag, "_load_psum"}, t, 64'(load_psum),       64'(0));
        chk({tag, "_sel"},       t, 64'(sel_pe_reg),      64'(0));
        chk({tag, "_ia"},        t, 64'(ia),              64'(0));
        chk({tag, "_ia_sign"},   t, 64'(ia_sign),         64'(0));
        chk({tag, "_out_valid"}, t, 64'(out_valid),       64'(0));
    endtask

    // One pass: L elements, valid pattern vp (then vdef), drain ready pattern rp.
    // vout drives src_valid outside the streaming window; restart re-pulses
    // start mid-pass and in the final cycle; abort_word>=0 resets during drain.
    task automatic run_pass(input int L, input logic [N-1:0] mask, input logic [31:0] vp,
                            input bit vdef, input bit vout, input logic [3:0] rp,
                            input bit restart, input int abort_word);
        logic [DW-1:0] ed[$];
        logic          es[$];
        logic [PW-1:0] words[N];
        bit            acc_at[512];
        int            acc_idx[512];
        logic [N-1:0]  e1, e2;
        int t, j, n, ta, t_load, t_done, k, c, nacc;
        bit in_acc, v, in_drain, hs;

        for (int e = 0; e < L; e++) begin
            ed.push_back(DW'($urandom));
            es.push_back(1'($urandom));
        end
        for (int i = 0; i < N; i++) bias_arr[i] = $urandom;
        for (int i = 0; i < 512; i++) begin acc_at[i] = 0; acc_idx[i] = 0; end

        // Expected schedule: CLR at 1, BIAS at 2, streaming from 3
        t = 3; j = 0; n = 0; ta = 2;
        while (n < L) begin
            if ((j < 32) ? vp[j] : vdef) begin
                acc_at[t] = 1; acc_idx[t] = n; n++; ta = t;
            end
            t++; j++;
        end
        t_load = (L > 0) ? ta + 2 : 3;
        t = t_load + 1; k = 0; c = 0;
        while (k < N) begin
            if (rp[c % 4]) k++;
            t++; c++;
        end
        t_done = t;

        // Expected results, last PE first
        for (int kk = 0; kk < N; kk++) begin
            int p;
            p = N - 1 - kk;
            words[kk] = bias_arr[p];
            if (mask[p]) begin
                for (int e = 0; e < L; e++) words[kk] += elem_val(ed[e], es[e]) * PW'(p + 1);
            end
        end

        vec_len = LW'(L);
        pe_mask = mask;
        k = 0; c = 0; nacc = 0;
        for (t = 0; t <= t_done + 2; t++) begin
            @(posedge clk); #1;
            in_acc   = (L > 0) && (t >= 3) && (t <= ta);
            v        = in_acc ? (((t - 3) < 32) ? vp[t-3] : vdef) : vout;
            in_drain = (t > t_load) && (t < t_done);
            hs       = in_drain && rp[c % 4];
            start     = (t == 0) || (restart && (t == 5 || t == t_done));
            src_valid = v;
            src_ia    = (in_acc && v) ? ed[nacc] : DW'($urandom);
            src_sign  = (in_acc && v) ? es[nacc] : 1'($urandom);
            out_ready = in_drain ? rp[c % 4] : 1'b1;
            if (abort_word >= 0 && in_drain && k == abort_word) begin
                #1 reset = 1'b0;
                #1 check_zero("abort_async", t);
                start = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
                @(posedge clk); #1;
                check_zero("abort_edge", t + 1);
                reset = 1'b1;
                repeat (4) @(posedge clk);
                #1 check_zero("abort_idle", t + 5);
                return;
            end
            @(negedge clk);
            e1 = (t >= 1 && acc_at[t-1]) ? mask : '0;
            e2 = (t >= 2 && acc_at[t-2]) ? mask : '0;
            chk("busy",      t, 64'(busy),            64'((t >= 1) && (t <= t_done)));
            chk("done",      t, 64'(done),            64'(t == t_done));
            chk("relu",      t, 64'(rst_pe_relu_reg), 64'(t == 1));
            chk("load_bias", t, 64'(load_bias),       64'(t == 2));
            chk("src_ready", t, 64'(src_ready),       64'(in_acc));
            chk("wea_reg1",  t, 64'(wea_reg1),        64'(e1));
            chk("wea_reg2",  t, 64'(wea_reg2),        64'(e2));
            if (t >= 1 && acc_at[t-1]) begin
                chk("ia",      t, 64'(ia),      64'(ed[acc_idx[t-1]]));
                chk("ia_sign", t, 64'(ia_sign), 64'(es[acc_idx[t-1]]));
            end
            chk("load_psum", t, 64'(load_psum),  64'(t == t_load));
            chk("sel",       t, 64'(sel_pe_reg), 64'((t >= t_load) && (t < t_done)));
            chk("out_valid", t, 64'(out_valid),  64'(in_drain));
            chk("shift",     t, 64'(shift),      64'(hs));
            if (in_drain) chk("out_data", t, 64'(out_data), 64'(words[k]));
            if (in_acc && v) nacc++;
            if (hs) k++;
            if (in_drain) c++;
        end
        start = 1'b0; src_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; vec_len = '0; pe_mask = '0;
        src_valid = 1'b0; src_ia = '0; src_sign = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset", 0);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_zero("post_reset", 0);

        // Full mask, continuous valid and ready: done 25 cycles after start
        run_pass(4, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b1111, 1'b0, -1);
        // Valid gaps 1,0,0,1,0,1
        run_pass(3, 16'hFFFF, 32'h0000_0029, 1'b0, 1'b0, 4'b1111, 1'b0, -1);
        // Empty vector: bias values only
        run_pass(0, 16'hFFFF, 32'h0, 1'b0, 1'b0, 4'b1111, 1'b0, -1);
        // Consumer stalls 1,0,0,1
        run_pass(5, N'($urandom), 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1001, 1'b0, -1);
        // Partial mask with ignored restarts
        run_pass(6, 16'h00F0, $urandom, 1'b1, 1'b0, 4'b1111, 1'b1, -1);
        // Abort at drain word 5, then a clean pass
        run_pass(4, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1111, 1'b0, 5);
        run_pass(2, 16'hA5C3, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1111, 1'b0, -1);
        // Randomized passes
        for (int r = 0; r < 4; r++) begin
            run_pass(int'($urandom_range(1, 8)), N'($urandom), $urandom, 1'b1,
                     1'($urandom), 4'($urandom) | 4'b0001, 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
